// File: rtl/mem_arb_pkg.sv
// Shared constants, state encoding and select helpers for mem_req_arbiter3.
package mem_arb_pkg;

  localparam int unsigned NUM_REQ = 3;

  localparam logic [1:0] SEL_IN0 = 2'b00;
  localparam logic [1:0] SEL_IN1 = 2'b01;
  localparam logic [1:0] SEL_IN2 = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RESP = 2'b10
  } state_t;

  // (sel + 1) mod 3; an illegal 11 folds back to requester 0.
  function automatic logic [1:0] sel_next(input logic [1:0] sel);
    case (sel)
      SEL_IN0: return SEL_IN1;
      SEL_IN1: return SEL_IN2;
      default: return SEL_IN0;
    endcase
  endfunction

  function automatic logic [2:0] sel_onehot(input logic [1:0] sel);
    case (sel)
      SEL_IN0: return 3'b001;
      SEL_IN1: return 3'b010;
      SEL_IN2: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/mux3.sv
// Three-input select mux with the standard 00/01/10 encoding.
module mux3
  import mem_arb_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic [1:0]   sel,
  input  logic [N-1:0] in0,
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  output logic [N-1:0] out
);

  always_comb begin
    case (sel)
      SEL_IN1: out = in1;
      SEL_IN2: out = in2;
      default: out = in0;
    endcase
  end

endmodule

// File: rtl/mem_req_arbiter3.sv
// Three-way arbiter for the shared memory port: one transaction at a time.
// Build with MEM_ARB_RR_EN for round robin; default is fixed priority 0 > 1 > 2.
module mem_req_arbiter3
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        req_valid,
  output logic [2:0]        req_ready,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [ADDR_W-1:0] req_addr2,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  input  logic [DATA_W-1:0] req_wdata2,
  input  logic [2:0]        req_we,
  output logic [2:0]        resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic              mem_req_we,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic [1:0]        grant_sel
);

  state_t     state, state_nxt;
  logic [1:0] winner;
  logic       we_mux;

`ifdef MEM_ARB_RR_EN
  logic [1:0] ptr;

  always_comb begin
    logic [1:0] cand;
    logic       found;
    winner = ptr;
    cand   = ptr;
    found  = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && ((req_valid & sel_onehot(cand)) != '0)) begin
        winner = cand;
        found  = 1'b1;
      end
      cand = sel_next(cand);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ptr <= SEL_IN0;
    else if (state == RESP && mem_resp_valid)
      ptr <= sel_next(grant_sel);
  end
`else
  always_comb begin
    if (req_valid[0])      winner = SEL_IN0;
    else if (req_valid[1]) winner = SEL_IN1;
    else                   winner = SEL_IN2;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant_sel <= SEL_IN0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_valid != '0)
        grant_sel <= winner;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid != '0) state_nxt = REQ;
      REQ:     if (mem_req_ready)   state_nxt = RESP;
      RESP:    if (mem_resp_valid)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Write enable is qualified by REQ so it reads 0 whenever no request is on the port.
  always_comb begin
    mem_req_valid = (state == REQ);
    mem_req_we    = (state == REQ) & we_mux;
    req_ready     = (state == REQ && mem_req_ready) ? sel_onehot(grant_sel) : '0;
    resp_valid    = (state == RESP && mem_resp_valid) ? sel_onehot(grant_sel) : '0;
  end

  assign resp_data = mem_resp_data;

  mux3 #(.N(ADDR_W)) u_addr_mux (
    .sel (grant_sel),
    .in0 (req_addr0),
    .in1 (req_addr1),
    .in2 (req_addr2),
    .out (mem_req_addr)
  );

  mux3 #(.N(DATA_W)) u_wdata_mux (
    .sel (grant_sel),
    .in0 (req_wdata0),
    .in1 (req_wdata1),
    .in2 (req_wdata2),
    .out (mem_req_wdata)
  );

  mux3 #(.N(1)) u_we_mux (
    .sel (grant_sel),
    .in0 (req_we[0]),
    .in1 (req_we[1]),
    .in2 (req_we[2]),
    .out (we_mux)
  );

endmodule

// File: tb/tb_mem_req_arbiter3.sv
// Self-checking bench for mem_req_arbiter3 (either MEM_ARB_RR_EN build).
module tb_mem_req_arbiter3;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req_valid, req_ready, req_we, resp_valid;
  logic [31:0] req_addr0, req_addr1, req_addr2;
  logic [31:0] req_wdata0, req_wdata1, req_wdata2;
  logic [31:0] resp_data, mem_req_addr, mem_req_wdata, mem_resp_data;
  logic        mem_req_valid, mem_req_ready, mem_req_we, mem_resp_valid;
  logic [1:0]  grant_sel;

  int errors = 0;
  int checks = 0;
  int m_ptr  = 0;
  int m_last = 0;

  always #5 clk = ~clk;

  mem_req_arbiter3 #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr0(req_addr0), .req_addr1(req_addr1), .req_addr2(req_addr2),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1), .req_wdata2(req_wdata2),
    .req_we(req_we), .resp_valid(resp_valid), .resp_data(resp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata), .mem_req_we(mem_req_we),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .grant_sel(grant_sel)
  );

  typedef struct {
    logic [2:0] v;
    logic [2:0] we;
    int         rdy;
    int         rsp;
    bit         stray;
    int         rr_g;
    int         fp_g;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arbitration straight from the rules: scan from ptr (RR) or from 0 (fixed).
  function automatic int pick(input logic [2:0] v);
`ifdef MEM_ARB_RR_EN
    for (int k = 0; k < 3; k++)
      if (v[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
`else
    for (int k = 0; k < 3; k++)
      if (v[k]) return k;
`endif
    return 0;
  endfunction

  function automatic logic [31:0] addr_of(input int g);
    return (g == 0) ? req_addr0 : (g == 1) ? req_addr1 : req_addr2;
  endfunction

  function automatic logic [31:0] wdata_of(input int g);
    return (g == 0) ? req_wdata0 : (g == 1) ? req_wdata1 : req_wdata2;
  endfunction

  // One full transaction from the IDLE cycle through the response strobe.
  task automatic txn(input logic [2:0] v, input logic [2:0] we, input int rdy_dly,
                     input int rsp_dly, input bit stray, input int exp_g,
                     input logic [31:0] rdata);
    int         g;
    logic [2:0] oh;
    g  = (exp_g >= 0) ? exp_g : pick(v);
    oh = 3'b001 << g;
    @(negedge clk);
    req_valid = v; req_we = we; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    #1;
    chk("idle_mem_req_valid", mem_req_valid, 0);
    chk("idle_grant_hold", grant_sel, m_last);
    chk("idle_req_ready", req_ready, 0);
    @(negedge clk); #1;
    chk("grant_sel", grant_sel, g);
    chk("mem_req_addr", mem_req_addr, addr_of(g));
    chk("mem_req_wdata", mem_req_wdata, wdata_of(g));
    chk("mem_req_we", mem_req_we, we[g]);
    for (int i = 0; i <= rdy_dly; i++) begin
      if (i > 0) @(negedge clk);
      mem_req_ready  = (i == rdy_dly);
      mem_resp_valid = stray && (i != rdy_dly);
      mem_resp_data  = $urandom;
      #1;
      chk("req_mem_req_valid", mem_req_valid, 1);
      chk("req_ready", req_ready, (i == rdy_dly) ? oh : 3'b000);
      chk("req_stray_resp", resp_valid, 0);
    end
    for (int i = 0; i <= rsp_dly; i++) begin
      @(negedge clk);
      mem_req_ready  = stray;
      mem_resp_valid = (i == rsp_dly);
      mem_resp_data  = rdata;
      #1;
      chk("resp_mem_req_valid", mem_req_valid, 0);
      chk("resp_req_ready", req_ready, 0);
      chk("resp_valid", resp_valid, (i == rsp_dly) ? oh : 3'b000);
      if (i == rsp_dly) chk("resp_data", resp_data, rdata);
    end
    m_ptr  = (g + 1) % 3;
    m_last = g;
  endtask

  vec_t tab[12];

  initial begin
    logic [2:0] rv;
    tab[0]  = '{3'b111, 3'b000, 0, 0, 1'b0, 0, 0};
    tab[1]  = '{3'b111, 3'b000, 0, 0, 1'b0, 1, 0};
    tab[2]  = '{3'b111, 3'b000, 0, 0, 1'b0, 2, 0};
    tab[3]  = '{3'b111, 3'b000, 0, 0, 1'b0, 0, 0};
    tab[4]  = '{3'b111, 3'b000, 0, 0, 1'b0, 1, 0};
    tab[5]  = '{3'b111, 3'b000, 0, 0, 1'b0, 2, 0};
    tab[6]  = '{3'b010, 3'b000, 1, 1, 1'b0, 1, 1};
    tab[7]  = '{3'b100, 3'b100, 0, 0, 1'b0, 2, 2};
    tab[8]  = '{3'b011, 3'b010, 5, 2, 1'b1, 0, 0};
    tab[9]  = '{3'b101, 3'b000, 2, 0, 1'b1, 2, 0};
    tab[10] = '{3'b110, 3'b000, 0, 3, 1'b0, 1, 1};
    tab[11] = '{3'b011, 3'b000, 0, 0, 1'b0, 0, 0};

    rst = 1'b1; req_valid = '0; req_we = 3'b001;
    req_addr0 = 32'h40; req_addr1 = 32'h100; req_addr2 = 32'h200;
    req_wdata0 = 32'h0A0A0A0A; req_wdata1 = 32'h0B0B0B0B; req_wdata2 = 32'h12345678;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    @(negedge clk); #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_grant_sel", grant_sel, 0);
    chk("rst_mem_req_we", mem_req_we, 0);
    chk("rst_mem_req_addr", mem_req_addr, 32'h40);
    chk("rst_mem_req_wdata", mem_req_wdata, 32'h0A0A0A0A);
    @(negedge clk);
    rst = 1'b0; req_we = '0;

    foreach (tab[i]) begin
`ifdef MEM_ARB_RR_EN
      txn(tab[i].v, tab[i].we, tab[i].rdy, tab[i].rsp, tab[i].stray, tab[i].rr_g, 32'hDEADBEEF);
`else
      txn(tab[i].v, tab[i].we, tab[i].rdy, tab[i].rsp, tab[i].stray, tab[i].fp_g, 32'hDEADBEEF);
`endif
    end

    // Asynchronous reset while a transaction sits in RESP.
    @(negedge clk);
    req_valid = 3'b111; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    @(negedge clk);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    #1;
    chk("pre_rst_in_resp", mem_req_valid, 0);
    rst = 1'b1; req_valid = '0; req_we = 3'b111; mem_resp_valid = 1'b1;
    #1;
    chk("arst_req_ready", req_ready, 0);
    chk("arst_resp_valid", resp_valid, 0);
    chk("arst_mem_req_valid", mem_req_valid, 0);
    chk("arst_grant_sel", grant_sel, 0);
    chk("arst_mem_req_we", mem_req_we, 0);
    chk("arst_mem_req_addr", mem_req_addr, req_addr0);
    @(negedge clk);
    rst = 1'b0; req_we = '0;
    #1;
    chk("post_rst_resp_valid", resp_valid, 0);
    chk("post_rst_mem_req_valid", mem_req_valid, 0);
    m_ptr = 0; m_last = 0;
    txn(3'b111, 3'b000, 0, 0, 1'b0, 0, 32'hCAFEF00D);

    for (int n = 0; n < 40; n++) begin
      rv = 3'($urandom_range(1, 7));
      req_addr0  = $urandom; req_addr1  = $urandom; req_addr2  = $urandom;
      req_wdata0 = $urandom; req_wdata1 = $urandom; req_wdata2 = $urandom;
      txn(rv, 3'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
          1'($urandom), -1, $urandom);
    end

    @(negedge clk);
    req_valid = '0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
